modred_p25519: RTL and testbench

//   Reduces a 510-bit product modulo p = 2^255-19 to a canonical residue in [0, p-1].

---
 rtl/p25519_pkg.sv | 30 +++
 rtl/mul_c19.sv | 15 +
 rtl/modred_p25519.sv | 128 ++++++++++++
 tb/tb_modred_p25519.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/p25519_pkg.sv
// Shared constants and FSM state type for the p = 2^255-19 reducer.
// The state set depends on MODRED_FAST_FOLD_EN (single merged FOLD state when defined).
package p25519_pkg;

  localparam int DATA_W = 255;
  localparam int FOLD_C = 19;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 260;

  // p = 2^DATA_W - FOLD_C, i.e. all ones minus (FOLD_C - 1)
  localparam logic [DATA_W-1:0] P_MOD = ~(DATA_W'(0)) - DATA_W'(FOLD_C - 1);

`ifdef MODRED_FAST_FOLD_EN
  typedef enum logic [2:0] {
    IDLE,
    FOLD,
    SUB,
    DONE
  } modred_state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    FOLD1,
    FOLD2,
    SUB,
    DONE
  } modred_state_t;
`endif

endpackage

// File: rtl/mul_c19.sv
// Combinational multiply by the fold constant 19 using shift-add: (x<<4) + (x<<1) + x.
// The output is 5 bits wider than the input, so no carry can be lost.
module mul_c19 #(
  parameter int IN_W = 255
) (
  input  logic [IN_W-1:0] i_x,
  output logic [IN_W+4:0] o_y
);

  logic [IN_W+4:0] w_x;

  assign w_x = {5'b0, i_x};
  assign o_y = (w_x << 4) + (w_x << 1) + w_x;

endmodule

// File: rtl/modred_p25519.sv
// Reduces a 510-bit product modulo 2^255-19 to a canonical residue by folding 2^255 == 19.
// Build option MODRED_FAST_FOLD_EN merges the two fold stages into one cycle.
module modred_p25519
  import p25519_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int TOP_W = ACC_W - DATA_W;

  modred_state_t r_state;
  modred_state_t w_next;

  logic [PROD_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_out_data;

  logic [ACC_W-1:0]   w_c19_hi;
  logic [ACC_W-1:0]   w_fold1;
  logic [TOP_W-1:0]   w_fold2_hi;
  logic [DATA_W-1:0]  w_fold2_lo;
  logic [TOP_W+4:0]   w_c19_top;
  logic [DATA_W:0]    w_fold2;
  logic               w_ge_p;
  logic [DATA_W-1:0]  w_sub;

  // First fold: low 255 bits plus 19 times the upper 255 bits; fits in ACC_W bits.
  mul_c19 #(.IN_W(PROD_W - DATA_W)) u_fold1_mul (
    .i_x (r_acc[PROD_W-1:DATA_W]),
    .o_y (w_c19_hi)
  );

  assign w_fold1 = {{TOP_W{1'b0}}, r_acc[DATA_W-1:0]} + w_c19_hi;

`ifdef MODRED_FAST_FOLD_EN
  assign {w_fold2_hi, w_fold2_lo} = w_fold1;
`else
  assign {w_fold2_hi, w_fold2_lo} = r_acc[ACC_W-1:0];
`endif

  mul_c19 #(.IN_W(TOP_W)) u_fold2_mul (
    .i_x (w_fold2_hi),
    .o_y (w_c19_top)
  );

  // Second fold result is below 2^255 + 361 < 2p, so one conditional subtract suffices.
  assign w_fold2 = {1'b0, w_fold2_lo} + (DATA_W + 1)'(w_c19_top);
  assign w_ge_p  = r_acc[DATA_W:0] >= {1'b0, P_MOD};
  assign w_sub   = r_acc[DATA_W-1:0] - P_MOD;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
`ifdef MODRED_FAST_FOLD_EN
          w_next = FOLD;
`else
          w_next = FOLD1;
`endif
        end
      end
`ifdef MODRED_FAST_FOLD_EN
      FOLD:  w_next = SUB;
`else
      FOLD1: w_next = FOLD2;
      FOLD2: w_next = SUB;
`endif
      SUB:   w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the datapath is cleared on reset as well, so an abandoned operation leaves nothing visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc <= in_data;
          end
        end
`ifdef MODRED_FAST_FOLD_EN
        FOLD:  r_acc <= {{(PROD_W - DATA_W - 1){1'b0}}, w_fold2};
`else
        FOLD1: r_acc <= {{(PROD_W - ACC_W){1'b0}}, w_fold1};
        FOLD2: r_acc <= {{(PROD_W - DATA_W - 1){1'b0}}, w_fold2};
`endif
        SUB:   r_out_data <= w_ge_p ? w_sub : r_acc[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  assign out_data = r_out_data;

endmodule

// File: tb/tb_modred_p25519.sv
// Self-checking bench for modred_p25519: directed vector table, backpressure and reset
// sequences, and back-to-back random products checked against a plain modulo reference.
module tb_modred_p25519;

  localparam int PW = 510;
  localparam int DW = 255;
`ifdef MODRED_FAST_FOLD_EN
  localparam int LAT = 3;
  localparam int II  = 4;
`else
  localparam int LAT = 4;
  localparam int II  = 5;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  modred_p25519 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [PW-1:0] din;
    logic [PW-1:0] exp;
    string         name;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] p_full();
    return (PW'(1) << 255) - PW'(19);
  endfunction

  function automatic logic [PW-1:0] ref_mod(input logic [PW-1:0] x);
    logic [PW-1:0] p;
    p = p_full();
    return x % p;
  endfunction

  function automatic logic [PW-1:0] rand_wide();
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = {r[PW-33:0], $urandom()};
    return r;
  endfunction

  // Present din, wait (bounded) for acceptance, then wait (bounded) for out_valid.
  task automatic run_op(input logic [PW-1:0] din, input bit hold_valid,
                        output logic [DW-1:0] res, output int lat, output int acc_cyc);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = din;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = hold_valid;
    in_data  = rand_wide();
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    res = out_data;
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [PW-1:0] pm1;
    logic [PW-1:0] din;
    logic [DW-1:0] res;
    int            lat;
    int            ac;
    int            prev_ac;
    int            seen;

    p   = p_full();
    pm1 = p - 1;
    vecs[0] = '{din: '0,                    exp: '0,          name: "zero"};
    vecs[1] = '{din: p,                     exp: '0,          name: "p"};
    vecs[2] = '{din: pm1,                   exp: pm1,         name: "p_minus_1"};
    vecs[3] = '{din: PW'(1) << 255,         exp: PW'(19),     name: "two_255"};
    vecs[4] = '{din: pm1 * pm1,             exp: PW'(1),      name: "pm1_squared"};
    vecs[5] = '{din: ~(PW'(0)),             exp: PW'(360),    name: "all_ones"};

    rst = 1'b1;
    repeat (3) tick();
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_out_data",  out_data,  0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      run_op(vecs[i].din, 1'b0, res, lat, ac);
      check({vecs[i].name, "_data"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, LAT);
      tick();
      check({vecs[i].name, "_back_idle"}, busy, 0);
    end

    // Backpressure: result must hold and new input must be refused.
    out_ready = 1'b0;
    run_op(PW'(1) << 255, 1'b0, res, lat, ac);
    check("bp_data_first", res, 19);
    in_valid = 1'b1;
    in_data  = rand_wide();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data",  out_data,  19);
      check("bp_in_ready",  in_ready,  0);
      check("bp_busy",      busy,      1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_rel_in_ready",  in_ready,  1);
    check("bp_rel_out_valid", out_valid, 0);
    check("bp_rel_busy",      busy,      0);
    seen = 0;
    repeat (LAT + 2) begin
      tick();
      if (busy || out_valid) seen = 1;
    end
    check("bp_input_ignored", seen, 0);

    // Reset two cycles into an operation.
    in_valid = 1'b1;
    in_data  = ~(PW'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    check("rst_mid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    check("rst_mid_in_ready",  in_ready,  1);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_out_data",  out_data,  0);
    check("rst_mid_busy",      busy,      0);
    rst  = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("rst_mid_no_stale", seen, 0);

    // Back-to-back random products with out_ready held high.
    out_ready = 1'b1;
    prev_ac   = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) din = p * (rand_wide() >> 255) + PW'(i);
      else            din = rand_wide();
      run_op(din, 1'b1, res, lat, ac);
      check("rnd_data", res, ref_mod(din));
      check("rnd_latency", lat, LAT);
      if (i > 0) check("rnd_spacing", ac - prev_ac, II);
      prev_ac = ac;
    end
    in_valid = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
